// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : IF stage: owns the PC, issues req/ready fetches to instruction
//               memory and holds one fetched word for IF/ID. Optional halt
//               support is enabled with the FETCH_HALT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] NOP_INSTR  = 16'h0800,
    parameter logic [15:0] HALT_INSTR = 16'hF000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ready,
    output logic [15:0] instruction,
    output logic [15:0] PC_inc,
    output logic        fetch_valid,
    output logic        flush,
    output logic        halted
);

    localparam logic [1:0] c_st_fetch  = 2'd0;
    localparam logic [1:0] c_st_drain  = 2'd1;
    localparam logic [1:0] c_st_halted = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [15:0] r_pc;
    logic [15:0] r_drain_addr;
    logic [15:0] r_instr;
    logic [15:0] r_pc_inc;
    logic        r_valid;
    logic        w_req;
    logic        w_fire;
    logic        w_halt_hit;

`ifdef FETCH_HALT_EN
    assign w_halt_hit = (imem_rdata == HALT_INSTR);
    assign halted     = (r_state == c_st_halted);
`else
    logic w_unused_halt;
    assign w_unused_halt = ^HALT_INSTR;
    assign w_halt_hit    = 1'b0;
    assign halted        = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_fetch;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a redirect with an outstanding request must wait
    // for the stale response before fetching from the new PC.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_fetch: begin
                if (branch_taken) begin
                    if (w_req && !imem_ready) begin
                        w_state_nxt = c_st_drain;
                    end
                end else if (w_fire && w_halt_hit) begin
                    w_state_nxt = c_st_halted;
                end
            end
            c_st_drain: begin
                if (imem_ready) begin
                    w_state_nxt = c_st_fetch;
                end
            end
            c_st_halted: w_state_nxt = c_st_halted;
            default:     w_state_nxt = c_st_fetch;
        endcase
    end

    // Output logic
    always_comb begin
        w_req     = 1'b0;
        imem_addr = r_pc;
        case (r_state)
            c_st_fetch: w_req = ~rst & (~r_valid | ~stall);
            c_st_drain: begin
                w_req     = ~rst;
                imem_addr = r_drain_addr;
            end
            default:    w_req = 1'b0;
        endcase
    end

    assign imem_req = w_req;
    assign w_fire   = w_req & imem_ready;
    assign flush    = branch_taken & ~rst;

    // PC and slot datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_drain_addr <= RESET_PC;
            r_instr      <= NOP_INSTR;
            r_pc_inc     <= 16'h0000;
            r_valid      <= 1'b0;
        end else if (branch_taken) begin
            if (r_state != c_st_halted) begin
                r_pc <= branch_target & 16'hFFFE;
            end
            if (r_state == c_st_fetch) begin
                r_drain_addr <= r_pc;
            end
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (r_state == c_st_fetch && w_fire) begin
            r_instr  <= imem_rdata;
            r_pc_inc <= r_pc + 16'd2;
            r_valid  <= 1'b1;
            r_pc     <= r_pc + 16'd2;
        end else if (!stall) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end
    end

    assign instruction = r_instr;
    assign PC_inc      = r_pc_inc;
    assign fetch_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit; a second
//               instance starts at 16'hFFFE to exercise PC wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        imem_ready;
    logic        ovr_en;
    logic [15:0] ovr_val;

    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] instruction;
    logic [15:0] PC_inc;
    logic        fetch_valid;
    logic        flush;
    logic        halted;

    logic        req_w;
    logic [15:0] addr_w;
    logic [15:0] rdata_w;
    logic [15:0] instr_w;
    logic [15:0] pc_inc_w;
    logic        valid_w;
    logic        flush_w;
    logic        halted_w;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign imem_rdata = ovr_en ? ovr_val : (imem_addr ^ 16'hA000);
    assign rdata_w    = addr_w ^ 16'hA000;

    fetch_unit u_dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_ready(imem_ready), .instruction(instruction), .PC_inc(PC_inc),
        .fetch_valid(fetch_valid), .flush(flush), .halted(halted)
    );

    fetch_unit #(.RESET_PC(16'hFFFE)) u_dut_wrap (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(req_w), .imem_addr(addr_w), .imem_rdata(rdata_w),
        .imem_ready(imem_ready), .instruction(instr_w), .PC_inc(pc_inc_w),
        .fetch_valid(valid_w), .flush(flush_w), .halted(halted_w)
    );

    task automatic check_val(input string tag, input logic [15:0] got,
                             input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0;
        imem_ready = 1'b1; ovr_en = 1'b0; ovr_val = 16'h0;
        step();
        step();
        check_val("rst_instr", instruction, 16'h0800);
        check_val("rst_pcinc", PC_inc, 16'h0000);
        check_val("rst_valid", fetch_valid, 1'b0);
        check_val("rst_halted", halted, 1'b0);
        check_val("rst_req", imem_req, 1'b0);
        branch_taken = 1'b1;
        #1;
        check_val("rst_flush", flush, 1'b0);
        branch_taken = 1'b0;

        // Streaming fetch with zero-wait memory
        @(negedge clk); rst = 1'b0; #1;
        check_val("t1_req0", imem_req, 1'b1);
        check_val("t1_addr0", imem_addr, 16'h0000);
        check_val("t4_addr0", addr_w, 16'hFFFE);
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("t1_instr", instruction, 16'hA000 | 16'(2 * i));
            check_val("t1_pcinc", PC_inc, 16'(2 * i + 2));
            check_val("t1_valid", fetch_valid, 1'b1);
            if (i < 3) check_val("t1_addr", imem_addr, 16'(2 * i + 2));
            if (i == 0) begin
                check_val("t4_pcinc", pc_inc_w, 16'h0000);
                check_val("t4_addr1", addr_w, 16'h0000);
            end
        end

        // Stall with a full slot
        @(negedge clk); stall = 1'b1; #1;
        check_val("t2_req", imem_req, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("t2_instr", instruction, 16'hA006);
            check_val("t2_pcinc", PC_inc, 16'h0008);
            check_val("t2_valid", fetch_valid, 1'b1);
            check_val("t2_req_h", imem_req, 1'b0);
        end
        @(negedge clk); stall = 1'b0; #1;
        check_val("t2_rel_req", imem_req, 1'b1);
        check_val("t2_rel_addr", imem_addr, 16'h0008);
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("t2_instr2", instruction, 16'hA000 | 16'(8 + 2 * i));
        end

        // Redirect while a request is outstanding -> DRAIN
        @(negedge clk); imem_ready = 1'b0; #1;
        check_val("t3_req", imem_req, 1'b1);
        check_val("t3_addr", imem_addr, 16'h0010);
        branch_taken = 1'b1; branch_target = 16'h0041; #1;
        check_val("t3_flush", flush, 1'b1);
        step();
        check_val("t3_instr", instruction, 16'h0800);
        check_val("t3_valid", fetch_valid, 1'b0);
        @(negedge clk); branch_taken = 1'b0; #1;
        check_val("t3_drain_req", imem_req, 1'b1);
        check_val("t3_drain_addr", imem_addr, 16'h0010);
        step();
        check_val("t3_drain_addr2", imem_addr, 16'h0010);
        @(negedge clk); imem_ready = 1'b1;
        step();
        check_val("t3_disc_valid", fetch_valid, 1'b0);
        check_val("t3_disc_instr", instruction, 16'h0800);
        check_val("t3_new_addr", imem_addr, 16'h0040);
        step();
        check_val("t3_new_instr", instruction, 16'hA040);
        check_val("t3_new_pcinc", PC_inc, 16'h0042);

        // Slot empties when consumed with no new word
        @(negedge clk); imem_ready = 1'b0;
        step();
        check_val("empty_valid", fetch_valid, 1'b0);
        check_val("empty_instr", instruction, 16'h0800);

        // Branch beats stall and ready: word dropped, no DRAIN
        @(negedge clk);
        stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0100; imem_ready = 1'b1;
        #1;
        check_val("t5_req", imem_req, 1'b1);
        check_val("t5_flush", flush, 1'b1);
        step();
        check_val("t5_valid", fetch_valid, 1'b0);
        check_val("t5_instr", instruction, 16'h0800);
        @(negedge clk); branch_taken = 1'b0; stall = 1'b0; #1;
        check_val("t5_req2", imem_req, 1'b1);
        check_val("t5_addr", imem_addr, 16'h0100);
        step();
        check_val("t5_instr2", instruction, 16'hA100);
        check_val("t5_pcinc", PC_inc, 16'h0102);

        // Halt encoding
        @(negedge clk); ovr_en = 1'b1; ovr_val = 16'hF000;
        step();
        check_val("t6_instr", instruction, 16'hF000);
        check_val("t6_pcinc", PC_inc, 16'h0104);
`ifdef FETCH_HALT_EN
        check_val("t6_halted", halted, 1'b1);
        check_val("t6_req", imem_req, 1'b0);
        @(negedge clk); ovr_en = 1'b0; branch_taken = 1'b1; branch_target = 16'h0200; #1;
        check_val("t6_flush", flush, 1'b1);
        step();
        @(negedge clk); branch_taken = 1'b0; #1;
        check_val("t6_req2", imem_req, 1'b0);
        check_val("t6_pc_frozen", imem_addr, 16'h0104);
        check_val("t6_halted2", halted, 1'b1);
        check_val("t6_drained", fetch_valid, 1'b0);
`else
        check_val("t6_no_halt", halted, 1'b0);
        check_val("t6_req", imem_req, 1'b1);
        check_val("t6_addr", imem_addr, 16'h0104);
        @(negedge clk); ovr_en = 1'b0;
        step();
        check_val("t6_next", instruction, 16'hA104);
`endif

        // Reset again from mid-run
        @(negedge clk); rst = 1'b1; #1;
        check_val("rst2_req", imem_req, 1'b0);
        step();
        check_val("rst2_instr", instruction, 16'h0800);
        check_val("rst2_valid", fetch_valid, 1'b0);
        check_val("rst2_pcinc", PC_inc, 16'h0000);
        check_val("rst2_halted", halted, 1'b0);
        @(negedge clk); rst = 1'b0; #1;
        check_val("rst2_addr", imem_addr, 16'h0000);
        check_val("rst2_req2", imem_req, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
